// File: rtl/led_scanner.sv
// Multiplexed 7-segment scanner: one digit slot per CLK_DIV clocks,
// with a pending/shadow buffer so displayed data only changes at frame edges.
module led_scanner #(
    parameter int CLK_DIV = 50000,
    parameter int NUM_DIG = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_value,
    input  logic [7:0]  i_dp,
    input  logic        i_blank_lz,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [4:0]  o_dig_ctrl,
    output logic [7:0]  o_dig_en,
    output logic        o_frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIG - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic          tick;
    logic          boundary;
    logic          accept;
    logic          load;

    logic          pend_full;
    logic [31:0]   pend_value;
    logic [7:0]    pend_dp;
    logic          pend_blz;

    logic [31:0]   sh_value;
    logic [7:0]    sh_dp;
    logic          sh_blz;

    logic [31:0]   nx_value;
    logic [7:0]    nx_dp;
    logic          nx_blz;

    logic [3:0]    nib;
    logic          dpb;
    logic          nz;
    logic          blank;

    assign o_ready = !pend_full;

    always_comb begin
        tick     = (cnt == CNT_LAST);
        boundary = tick && (idx == IDX_LAST);
        accept   = i_valid && !pend_full;
        load     = boundary && pend_full;
        idx_nxt  = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;

        // The slot being entered must already see a shadow load at this edge
        nx_value = load ? pend_value : sh_value;
        nx_dp    = load ? pend_dp    : sh_dp;
        nx_blz   = load ? pend_blz   : sh_blz;

        nib = nx_value[{idx_nxt, 2'b00} +: 4];
        dpb = nx_dp[idx_nxt];

        nz = 1'b0;
        for (int j = 0; j < NUM_DIG; j++) begin
            if (j >= int'(idx_nxt)) begin
                if (nx_value[4*j +: 4] != 4'h0 || nx_dp[j]) begin
                    nz = 1'b1;
                end
            end
        end
        blank = nx_blz && (idx_nxt != 3'd0) && !nz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= 3'd0;
            pend_full    <= 1'b0;
            pend_value   <= 32'h0;
            pend_dp      <= 8'h0;
            pend_blz     <= 1'b0;
            sh_value     <= 32'h0;
            sh_dp        <= 8'h0;
            sh_blz       <= 1'b0;
            o_dig_ctrl   <= 5'h00;
            o_dig_en     <= 8'hFE;
            o_frame_done <= 1'b0;
        end else begin
            cnt          <= tick ? '0 : cnt + CW'(1);
            o_frame_done <= boundary;

            if (tick) begin
                idx <= idx_nxt;
                if (blank) begin
                    o_dig_ctrl <= 5'h00;
                    o_dig_en   <= 8'hFF;
                end else begin
                    o_dig_ctrl <= {dpb, nib};
                    o_dig_en   <= ~(8'h01 << idx_nxt);
                end
            end

            // accept needs pending empty, load needs it full: never both
            if (load) begin
                sh_value  <= pend_value;
                sh_dp     <= pend_dp;
                sh_blz    <= pend_blz;
                pend_full <= 1'b0;
            end

            if (accept) begin
                pend_value <= i_value;
                pend_dp    <= i_dp;
                pend_blz   <= i_blank_lz;
                pend_full  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_scanner.sv
// Directed testbench for led_scanner with CLK_DIV=4, NUM_DIG=8.
// Each slot is 4 clocks, a frame is 32 clocks.
module tb_led_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_value = 32'h0;
    logic [7:0]  i_dp = 8'h0;
    logic        i_blank_lz = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [4:0]  o_dig_ctrl;
    logic [7:0]  o_dig_en;
    logic        o_frame_done;

    int tests = 0;
    int fails = 0;

    localparam logic [7:0] EN_TAB [8] = '{
        8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F
    };

    localparam logic [31:0] BL_VAL [2] = '{32'h00000120, 32'h00000120};
    localparam logic [7:0]  BL_DP  [2] = '{8'h00, 8'h10};
    localparam logic [4:0]  BL_CTRL [2][8] = '{
        '{5'h00, 5'h02, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00},
        '{5'h00, 5'h02, 5'h01, 5'h00, 5'h10, 5'h00, 5'h00, 5'h00}
    };
    localparam logic [7:0]  BL_EN [2][8] = '{
        '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hFF, 8'hFF, 8'hFF}
    };

    led_scanner #(.CLK_DIV(4), .NUM_DIG(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_value      (i_value),
        .i_dp         (i_dp),
        .i_blank_lz   (i_blank_lz),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_dig_ctrl   (o_dig_ctrl),
        .o_dig_en     (o_dig_en),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_boundary();
        for (int i = 0; i < 100; i++) begin
            step();
            if (o_frame_done === 1'b1) return;
        end
        $display("FAIL wait_boundary: o_frame_done never seen in 100 cycles");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic accept_one(input logic [31:0] v, input logic [7:0] dp,
                              input logic blz);
        i_value    = v;
        i_dp       = dp;
        i_blank_lz = blz;
        i_valid    = 1'b1;
        step();
        i_valid    = 1'b0;
        i_value    = 32'hDEAD_BEEF;
        i_dp       = 8'hA5;
        i_blank_lz = 1'b0;
    endtask

    task automatic test_reset();
        i_valid = 1'b1;
        i_value = 32'hFFFF_FFFF;
        i_dp    = 8'hFF;
        do_reset();
        i_valid = 1'b0;
        tests++;
        if (o_dig_en !== 8'hFE) begin
            fails++;
            $display("FAIL reset_en: got %h exp fe", o_dig_en);
        end
        tests++;
        if (o_dig_ctrl !== 5'h00) begin
            fails++;
            $display("FAIL reset_ctrl: got %h exp 00", o_dig_ctrl);
        end
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b exp 1", o_ready);
        end
        tests++;
        if (o_frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_fd: got %b exp 0", o_frame_done);
        end
        step();
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_prio_accept: ready %b exp 1", o_ready);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            tests++;
            if (o_dig_en !== EN_TAB[k/4] || o_dig_ctrl !== 5'h00 ||
                o_frame_done !== 1'b0) begin
                fails++;
                $display("FAIL idle[%0d]: en=%h ctrl=%h fd=%b exp en=%h ctrl=00 fd=0",
                         k, o_dig_en, o_dig_ctrl, o_frame_done, EN_TAB[k/4]);
            end
            step();
        end
        tests++;
        if (o_frame_done !== 1'b1 || o_dig_en !== 8'hFE) begin
            fails++;
            $display("FAIL idle_boundary: fd=%b en=%h exp fd=1 en=fe",
                     o_frame_done, o_dig_en);
        end
        step();
        tests++;
        if (o_frame_done !== 1'b0) begin
            fails++;
            $display("FAIL idle_fd_pulse: fd=%b exp 0", o_frame_done);
        end
    endtask

    task automatic test_update();
        bit bad;
        bit seen;
        step_n(5);
        accept_one(32'h89AB_CDEF, 8'h01, 1'b0);
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL upd_ready_low: got %b exp 0", o_ready);
        end
        bad  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (o_ready !== 1'b0 || o_dig_ctrl !== 5'h00) bad = 1'b1;
            step();
            if (o_frame_done === 1'b1) seen = 1'b1;
        end
        tests++;
        if (bad || !seen) begin
            fails++;
            $display("FAIL upd_old_frame: bad=%b boundary_seen=%b exp 0/1",
                     bad, seen);
        end
        tests++;
        if (o_dig_ctrl !== 5'h1F || o_dig_en !== 8'hFE || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL upd_dig0: ctrl=%h en=%h rdy=%b exp 1f fe 1",
                     o_dig_ctrl, o_dig_en, o_ready);
        end
        step_n(4);
        tests++;
        if (o_dig_ctrl !== 5'h0E || o_dig_en !== 8'hFD) begin
            fails++;
            $display("FAIL upd_dig1: ctrl=%h en=%h exp 0e fd",
                     o_dig_ctrl, o_dig_en);
        end
        step_n(24);
        tests++;
        if (o_dig_ctrl !== 5'h08 || o_dig_en !== 8'h7F) begin
            fails++;
            $display("FAIL upd_dig7: ctrl=%h en=%h exp 08 7f",
                     o_dig_ctrl, o_dig_en);
        end
    endtask

    task automatic test_hold();
        wait_boundary();
        accept_one(32'h1111_1111, 8'h00, 1'b0);
        i_value = 32'h2222_2222;
        i_dp    = 8'h00;
        i_valid = 1'b1;
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_ready_low: got %b exp 0", o_ready);
        end
        wait_boundary();
        tests++;
        if (o_dig_ctrl !== 5'h01 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_first: ctrl=%h rdy=%b exp 01 1",
                     o_dig_ctrl, o_ready);
        end
        step();
        i_valid = 1'b0;
        i_value = 32'h0;
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_capture: ready=%b exp 0", o_ready);
        end
        wait_boundary();
        tests++;
        if (o_dig_ctrl !== 5'h02) begin
            fails++;
            $display("FAIL hold_second: ctrl=%h exp 02", o_dig_ctrl);
        end
    endtask

    task automatic test_blank();
        for (int v = 0; v < 2; v++) begin
            accept_one(BL_VAL[v], BL_DP[v], 1'b1);
            wait_boundary();
            for (int k = 0; k < 32; k++) begin
                tests++;
                if (o_dig_ctrl !== BL_CTRL[v][k/4] ||
                    o_dig_en !== BL_EN[v][k/4]) begin
                    fails++;
                    $display("FAIL blank[%0d][%0d]: ctrl=%h en=%h exp %h %h",
                             v, k, o_dig_ctrl, o_dig_en,
                             BL_CTRL[v][k/4], BL_EN[v][k/4]);
                end
                step();
            end
        end
    endtask

    task automatic test_boundary_accept();
        step_n(31);
        accept_one(32'h0000_0005, 8'h00, 1'b0);
        tests++;
        if (o_frame_done !== 1'b1 || o_dig_ctrl !== 5'h00 || o_ready !== 1'b0) begin
            fails++;
            $display("FAIL bnd_same_cycle: fd=%b ctrl=%h rdy=%b exp 1 00 0",
                     o_frame_done, o_dig_ctrl, o_ready);
        end
        wait_boundary();
        tests++;
        if (o_dig_ctrl !== 5'h05 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL bnd_next: ctrl=%h rdy=%b exp 05 1",
                     o_dig_ctrl, o_ready);
        end
    endtask

    task automatic test_reset_mid();
        step_n(10);
        accept_one(32'h7777_7777, 8'hFF, 1'b0);
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL rmid_pending: ready=%b exp 0", o_ready);
        end
        step_n(2);
        do_reset();
        tests++;
        if (o_dig_en !== 8'hFE || o_dig_ctrl !== 5'h00 || o_ready !== 1'b1 ||
            o_frame_done !== 1'b0) begin
            fails++;
            $display("FAIL rmid_state: en=%h ctrl=%h rdy=%b fd=%b exp fe 00 1 0",
                     o_dig_en, o_dig_ctrl, o_ready, o_frame_done);
        end
        for (int k = 0; k < 32; k++) begin
            tests++;
            if (o_dig_en !== EN_TAB[k/4] || o_dig_ctrl !== 5'h00) begin
                fails++;
                $display("FAIL rmid_frame[%0d]: en=%h ctrl=%h exp %h 00",
                         k, o_dig_en, o_dig_ctrl, EN_TAB[k/4]);
            end
            step();
        end
        tests++;
        if (o_frame_done !== 1'b1 || o_dig_ctrl !== 5'h00) begin
            fails++;
            $display("FAIL rmid_discard: fd=%b ctrl=%h exp 1 00",
                     o_frame_done, o_dig_ctrl);
        end
    endtask

    initial begin
        step_n(2);
        test_reset();
        test_idle();
        test_update();
        test_hold();
        test_blank();
        test_boundary_accept();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_scanner.md
LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000; clocks per digit slot; legal range >= 2.
REQ-002 The block SHALL have parameter NUM_DIG, default 8; number of scanned digits; legal range 1..8.
REQ-003 The block SHALL have port clk, input, 1 bit; the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit; reset, synchronous and active-high.
REQ-005 The block SHALL have port i_value, input, 32 bits; hex digits, digit k = i_value[4k+3:4k].
REQ-006 The block SHALL have port i_dp, input, 8 bits; decimal point per digit, bit k = digit k.
REQ-007 The block SHALL have port i_blank_lz, input, 1 bit; leading-zero blanking enable.
REQ-008 The block SHALL have port i_valid, input, 1 bit; update request qualifying i_value/i_dp/i_blank_lz.
REQ-009 The block SHALL have port o_ready, output, 1 bit; pending buffer empty, update acceptable.
REQ-010 The block SHALL have port o_dig_ctrl, output, 5 bits; {dp, nibble} code for the 7-segment decoder.
REQ-011 The block SHALL have port o_dig_en, output, 8 bits; active-low digit select, at most one bit low.
REQ-012 The block SHALL have port o_frame_done, output, 1 bit; one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick = (count == CLK_DIV-1); width = clog2(CLK_DIV).
REQ-014 On tick, digit index idx SHALL advance idx -> (idx+1) mod NUM_DIG.
REQ-015 o_dig_ctrl and o_dig_en SHALL be registered and updated on the same edge as idx, reflecting the new idx and the data valid after that edge.
REQ-016 For displayed digit k, o_dig_en SHALL be all ones except bit k = 0, and o_dig_ctrl SHALL be {shadow_dp[k], shadow_value nibble k}.
REQ-017 o_dig_en bits >= NUM_DIG SHALL always be 1; i_value nibbles and i_dp bits >= NUM_DIG SHALL be ignored.
REQ-018 Handshake: accept SHALL occur when i_valid && o_ready; inputs are then captured into the pending buffer, and o_ready is 0 from the next cycle.
REQ-019 While o_ready = 0, i_valid SHALL be ignored, with no capture and no overwrite of pending.
REQ-020 Frame boundary = tick while idx == NUM_DIG-1; on that edge o_frame_done SHALL be 1 for exactly one cycle.
REQ-021 At a frame boundary with pending full, the shadow (value, dp, blank_lz) SHALL load from pending, pending SHALL empty, and o_ready SHALL be 1 from the next cycle.
REQ-022 Digit-0 output at that boundary edge SHALL already use the newly loaded shadow; the displayed data SHALL never change mid-frame.
REQ-023 If an accept and a frame boundary occur in the same cycle while pending is empty, the data SHALL go to pending only and load at the following boundary.
REQ-024 Blanking: digit k (k >= 1) SHALL be blanked when shadow_blank_lz = 1 and nibbles k..NUM_DIG-1 are all zero and dp bits k..NUM_DIG-1 are all zero.
REQ-025 Digit 0 SHALL never be blanked.
REQ-026 A blanked slot SHALL drive o_dig_en = 8'hFF and o_dig_ctrl = 5'h00 for its full duration.
REQ-027 Data inputs SHALL be sampled only on the accept cycle.

Reset
REQ-028 On rst, prescaler, idx, shadow value, shadow dp and shadow blank_lz SHALL all be set to 0.
REQ-029 On rst, pending SHALL be emptied.
REQ-030 On rst, o_ready SHALL be 1, o_dig_ctrl 5'h00, o_dig_en 8'hFE and o_frame_done 0, all visible the cycle after rst is sampled.
REQ-031 rst SHALL take priority over accept and tick in the same cycle, and any pending update SHALL be discarded.

Verification (CLK_DIV=4, NUM_DIG=8)
REQ-032 Idle after reset -> o_dig_en steps FE,FD,FB,...,7F every 4 clocks; o_dig_ctrl = 0x00 throughout; o_frame_done pulses every 32 clocks.
REQ-033 Mid-frame accept of i_value=0x89ABCDEF, i_dp=0x01 -> o_ready=0 until the boundary; the old digits finish the frame; next frame shows digit0 ctrl 0x1F and digit7 ctrl 0x08; o_ready=1 the cycle after.
REQ-034 Second i_valid=1 held while o_ready=0 -> not captured; it is captured in the first cycle o_ready=1 and displayed one frame later.
REQ-035 i_value=0x00000120, i_blank_lz=1, i_dp=0 -> digit slots 3..7 drive o_dig_en=FF; digit0 ctrl 0x00, digit1 ctrl 0x02, digit2 ctrl 0x01.
REQ-036 Accept on the exact boundary cycle -> the current boundary loads nothing new; the data appears at the next boundary.
REQ-037 rst asserted mid-frame with pending full -> next cycle o_dig_en=FE, o_dig_ctrl=0x00, o_ready=1; the pending value is never displayed.
